// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its PLL/reset-tree neighbours.
// slave is the sequencer side; master is the side that drives the PLL status.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       relock_req;
  logic       clear_fault;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  modport master (
    output pll_locked, relock_req, clear_fault,
    input  pll_rst, sys_rst_n, ready, fault, retry_cnt, state_o
  );

  modport slave (
    input  pll_locked, relock_req, clear_fault,
    output pll_rst, sys_rst_n, ready, fault, retry_cnt, state_o
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: pulses pll_rst, waits for a debounced lock with
// timeout and retry, then releases sys_rst_n; latches a fault after repeated failures.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_FILTER  = 256,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_lock_sequencer_if.slave   bus
);

  // Internal attempt count is wide enough for MAX_RETRY; only the visible copy saturates at 3.
  localparam int RW = (MAX_RETRY < 4) ? 2 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [1:0]       retry_vis_q, retry_vis_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             lock_meta_q, lock_s_q;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= bus.pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = FILTER;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q == RW'(MAX_RETRY - 1)) begin
            state_d = FAULT;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + RW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FILTER: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        if (!lock_s_q || bus.relock_req) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      end
      FAULT: begin
        if (bus.clear_fault) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
        retry_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies track state_q exactly.
    pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
    retry_vis_d = (retry_d > RW'(3)) ? 2'd3 : retry_d[1:0];
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      retry_vis_q <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      retry_vis_q <= retry_vis_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_vis_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: expectations are queued as stimulus is
// applied and popped when the corresponding DUT behaviour is measured.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES   = 16;
  localparam int LOCK_TIMEOUT = 50;
  localparam int LOCK_FILTER  = 8;
  localparam int MAX_RETRY    = 3;
  localparam int BOUND        = 300;

  logic refclk;
  logic rst_n;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] exp_q[$];

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_FILTER  (LOCK_FILTER),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d, no expectation queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0d, expected %0d", tag, obs, e);
      end
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return bus.pll_rst;
      1:       return bus.sys_rst_n;
      2:       return bus.ready;
      3:       return bus.fault;
      default: return (bus.state_o == 3'd2);
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, output int t);
    bit done;
    done = 1'b0;
    t    = -1;
    for (int i = 0; i < BOUND && !done; i++) begin
      if (get_sig(sel) === val) begin
        t    = cyc;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    n_chk++;
    assert (done) else begin
      n_fail++;
      $error("FAIL wait_sel%0d: observed timeout, expected value %0d", sel, val);
    end
  endtask

  initial begin
    int t0, t1, t2, t3, tl, tu, tf;

    rst_n           = 1'b0;
    bus.pll_locked  = 1'b0;
    bus.relock_req  = 1'b0;
    bus.clear_fault = 1'b0;
    repeat (3) tick();

    // Reset values
    expect_v(1); chk("rst_pll_rst", bus.pll_rst);
    expect_v(0); chk("rst_sys_rst_n", bus.sys_rst_n);
    expect_v(0); chk("rst_ready", bus.ready);
    expect_v(0); chk("rst_fault", bus.fault);
    expect_v(0); chk("rst_retry", bus.retry_cnt);
    expect_v(0); chk("rst_state", bus.state_o);

    // Power-up; lock rises 100 cycles after reset release
    rst_n = 1'b1;
    t0 = cyc;
    expect_v(RST_CYCLES);
    wait_sig(0, 1'b0, t1);
    chk("pwr_pll_rst_width", t1 - t0);
    while (cyc < t0 + 100) tick();
    bus.pll_locked = 1'b1;
    tl = cyc;
    expect_v(2 + LOCK_FILTER);
    wait_sig(1, 1'b1, t1);
    chk("pwr_lock_to_sysrst", t1 - (tl + 1));
    expect_v(1); chk("pwr_ready", bus.ready);
    expect_v(0); chk("pwr_retry", bus.retry_cnt);
    expect_v(3); chk("pwr_state", bus.state_o);

    // One-cycle lock drop in RUN
    t0 = cyc;
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    expect_v(3);
    wait_sig(1, 1'b0, t1);
    chk("drop_sysrst_latency", t1 - t0);
    expect_v(1); chk("drop_pll_rst_on", bus.pll_rst);
    expect_v(RST_CYCLES);
    wait_sig(0, 1'b0, t2);
    chk("drop_pll_rst_width", t2 - t1);
    expect_v(1 + LOCK_FILTER);
    wait_sig(2, 1'b1, t3);
    chk("drop_relock_time", t3 - t2);

    // relock_req in RUN
    t0 = cyc;
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    expect_v(1);
    wait_sig(1, 1'b0, t1);
    chk("rlk_sysrst_latency", t1 - t0);
    expect_v(RST_CYCLES);
    wait_sig(0, 1'b0, t2);
    chk("rlk_pll_rst_width", t2 - t1);
    expect_v(1 + LOCK_FILTER);
    wait_sig(2, 1'b1, t3);
    chk("rlk_ready_time", t3 - t2);

    // Lock lost; ignored pulses in WAIT_LOCK; one timeout; FILTER glitch
    bus.pll_locked = 1'b0;
    expect_v(RST_CYCLES);
    wait_sig(0, 1'b1, t1);
    wait_sig(0, 1'b0, t2);
    chk("lost_pll_rst_width", t2 - t1);
    repeat (5) tick();
    bus.relock_req  = 1'b1;
    bus.clear_fault = 1'b1;
    tick();
    bus.relock_req  = 1'b0;
    bus.clear_fault = 1'b0;
    repeat (2) tick();
    expect_v(1); chk("wait_ignore_state", bus.state_o);
    expect_v(0); chk("wait_ignore_pll_rst", bus.pll_rst);
    expect_v(LOCK_TIMEOUT);
    wait_sig(0, 1'b1, t3);
    chk("timeout_len", t3 - t2);
    expect_v(1); chk("timeout1_retry", bus.retry_cnt);
    expect_v(RST_CYCLES);
    wait_sig(0, 1'b0, t1);
    chk("retry_pll_rst_width", t1 - t3);
    bus.pll_locked = 1'b1;
    tl = cyc;
    expect_v(3);
    wait_sig(4, 1'b1, tf);
    chk("filter_entry", tf - tl);
    while (cyc < tl + 6) tick();
    bus.pll_locked = 1'b0;
    repeat (3) tick();
    bus.pll_locked = 1'b1;
    tu = cyc;
    expect_v(1); chk("glitch_state", bus.state_o);
    expect_v(1); chk("glitch_retry", bus.retry_cnt);
    expect_v(0); chk("glitch_ready", bus.ready);
    expect_v(3 + LOCK_FILTER);
    wait_sig(2, 1'b1, t1);
    chk("glitch_ready_time", t1 - tu);
    expect_v(0); chk("glitch_retry_clr", bus.retry_cnt);

    // Lock never returns: three attempts then FAULT
    bus.pll_locked = 1'b0;
    wait_sig(0, 1'b1, t1);
    for (int k = 1; k <= MAX_RETRY; k++) begin
      expect_v(RST_CYCLES);
      wait_sig(0, 1'b0, t2);
      chk("flt_pll_rst_width", t2 - t1);
      expect_v(LOCK_TIMEOUT);
      wait_sig(0, 1'b1, t1);
      chk("flt_timeout_len", t1 - t2);
      if (k < MAX_RETRY) begin
        expect_v(k); chk("flt_retry", bus.retry_cnt);
      end
    end
    expect_v(4); chk("flt_state", bus.state_o);
    expect_v(1); chk("flt_fault", bus.fault);
    expect_v(1); chk("flt_pll_rst", bus.pll_rst);
    expect_v(2); chk("flt_retry_hold", bus.retry_cnt);
    repeat (20) tick();
    expect_v(4); chk("flt_sticky", bus.state_o);
    t0 = cyc;
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    expect_v(0); chk("clr_state", bus.state_o);
    expect_v(0); chk("clr_retry", bus.retry_cnt);
    expect_v(0); chk("clr_fault", bus.fault);
    expect_v(1); chk("clr_pll_rst", bus.pll_rst);
    expect_v(1 + RST_CYCLES);
    wait_sig(0, 1'b0, t1);
    chk("clr_pll_rst_fall", t1 - t0);

    // Two more timeouts, then async reset mid-WAIT_LOCK
    wait_sig(0, 1'b1, t1);
    wait_sig(0, 1'b0, t1);
    wait_sig(0, 1'b1, t1);
    wait_sig(0, 1'b0, t1);
    expect_v(2); chk("pre_rst_retry", bus.retry_cnt);
    expect_v(1); chk("pre_rst_state", bus.state_o);
    repeat (10) tick();
    #3;
    rst_n = 1'b0;
    #1;
    expect_v(1); chk("arst_pll_rst", bus.pll_rst);
    expect_v(0); chk("arst_sys_rst_n", bus.sys_rst_n);
    expect_v(0); chk("arst_retry", bus.retry_cnt);
    expect_v(0); chk("arst_state", bus.state_o);
    expect_v(0); chk("arst_fault", bus.fault);
    @(posedge refclk);
    #1;
    rst_n = 1'b1;
    t0 = cyc;
    expect_v(RST_CYCLES);
    wait_sig(0, 1'b0, t1);
    chk("arst_pll_rst_width", t1 - t0);
    bus.pll_locked = 1'b1;
    tl = cyc;
    expect_v(3 + LOCK_FILTER);
    wait_sig(2, 1'b1, t2);
    chk("arst_ready_time", t2 - tl);
    expect_v(0); chk("arst_final_retry", bus.retry_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
